// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed driver for a common-anode style multi-digit 7-segment
// display. One digit is lit per slot of REFRESH_DIV clocks. A free-running PWM
// counter gates the lit time for brightness control. New display data is
// staged in a pending register and only becomes visible at a frame boundary,
// so a frame is never drawn with a mix of old and new data.
//
// Ports
//   FPGA_GlobalClock  in   single clock, rising edge
//   RST               in   synchronous active-high reset
//   Value             in   4*NR_DIGITS  hex nibble per digit (digit i = [4i+3:4i])
//   DP                in   NR_DIGITS    decimal point per digit
//   DigitEn           in   NR_DIGITS    per-digit enable, 0 = blanked
//   Load              in   capture strobe for Value/DP/DigitEn
//   Brightness        in   BRIGHT_BITS  PWM duty code, all-ones = always on
//   NA                out  NR_DIGITS    anode select (registered)
//   SEG               out  8            {dp, g..a} (registered)
//   LoadPending       out  captured data not yet on display
//   FrameDone         out  one-cycle pulse when the digit index wraps to 0
// -----------------------------------------------------------------------------
module seg_scan_driver #(
   parameter int NR_DIGITS        = 8,
   parameter int REFRESH_DIV      = 50000,
   parameter int BRIGHT_BITS      = 4,
   parameter int ANODE_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW   = 1
) (
   input  logic                     FPGA_GlobalClock,
   input  logic                     RST,
   input  logic [4*NR_DIGITS-1:0]   Value,
   input  logic [NR_DIGITS-1:0]     DP,
   input  logic [NR_DIGITS-1:0]     DigitEn,
   input  logic                     Load,
   input  logic [BRIGHT_BITS-1:0]   Brightness,
   output logic [NR_DIGITS-1:0]     NA,
   output logic [7:0]               SEG,
   output logic                     LoadPending,
   output logic                     FrameDone
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NR_DIGITS > 1) ? $clog2(NR_DIGITS) : 1;
   localparam logic [CNT_W-1:0]     SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NR_DIGITS - 1);
   // XOR masks that also serve as the inactive pin levels
   localparam logic [NR_DIGITS-1:0] NA_OFF    = {NR_DIGITS{ANODE_ACTIVE_LOW != 0}};
   localparam logic [7:0]           SEG_OFF   = {8{SEG_ACTIVE_LOW != 0}};

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0:    hex7 = 7'h3F;
         4'h1:    hex7 = 7'h06;
         4'h2:    hex7 = 7'h5B;
         4'h3:    hex7 = 7'h4F;
         4'h4:    hex7 = 7'h66;
         4'h5:    hex7 = 7'h6D;
         4'h6:    hex7 = 7'h7D;
         4'h7:    hex7 = 7'h07;
         4'h8:    hex7 = 7'h7F;
         4'h9:    hex7 = 7'h6F;
         4'hA:    hex7 = 7'h77;
         4'hB:    hex7 = 7'h7C;
         4'hC:    hex7 = 7'h39;
         4'hD:    hex7 = 7'h5E;
         4'hE:    hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   logic [CNT_W-1:0]       slot_q, slot_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [BRIGHT_BITS-1:0] pwm_q, pwm_d;
   logic [4*NR_DIGITS-1:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
   logic [NR_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
   logic [NR_DIGITS-1:0]   pend_en_q, pend_en_d, disp_en_q, disp_en_d;
   logic                   load_pend_q, load_pend_d;
   logic [NR_DIGITS-1:0]   na_q, na_d;
   logic [7:0]             seg_q, seg_d;

   logic                   slot_wrap, frame_wrap, lit;
   logic [3:0]             cur_nib;
   logic                   cur_dp, cur_en;

   always_comb begin
      slot_wrap   = (slot_q == SLOT_LAST);
      frame_wrap  = slot_wrap && (idx_q == IDX_LAST);

      slot_d      = slot_wrap ? '0 : slot_q + 1'b1;
      idx_d       = idx_q;
      if (slot_wrap) idx_d = frame_wrap ? '0 : idx_q + 1'b1;
      pwm_d       = pwm_q + 1'b1;

      pend_val_d  = pend_val_q;
      pend_dp_d   = pend_dp_q;
      pend_en_d   = pend_en_q;
      if (Load) begin
         pend_val_d = Value;
         pend_dp_d  = DP;
         pend_en_d  = DigitEn;
      end

      // A Load landing on the frame boundary bypasses the pending stage
      disp_val_d  = disp_val_q;
      disp_dp_d   = disp_dp_q;
      disp_en_d   = disp_en_q;
      if (frame_wrap) begin
         disp_val_d = Load ? Value   : pend_val_q;
         disp_dp_d  = Load ? DP      : pend_dp_q;
         disp_en_d  = Load ? DigitEn : pend_en_q;
      end

      load_pend_d = load_pend_q;
      if (frame_wrap)  load_pend_d = 1'b0;
      else if (Load)   load_pend_d = 1'b1;

      cur_nib = 4'h0;
      cur_dp  = 1'b0;
      cur_en  = 1'b0;
      for (int i = 0; i < NR_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_nib = disp_val_q[4*i +: 4];
            cur_dp  = disp_dp_q[i];
            cur_en  = disp_en_q[i];
         end
      end

      // All-ones brightness is full duty; otherwise pwm < code gives code/2^N
      lit   = cur_en && ((&Brightness) || (pwm_q < Brightness));
      na_d  = (lit ? (NR_DIGITS'(1) << idx_q) : '0) ^ NA_OFF;
      seg_d = (lit ? {cur_dp, hex7(cur_nib)} : 8'h00) ^ SEG_OFF;
   end

   always_ff @(posedge FPGA_GlobalClock) begin
      if (RST) begin
         slot_q      <= '0;
         idx_q       <= '0;
         pwm_q       <= '0;
         pend_val_q  <= '0;
         pend_dp_q   <= '0;
         pend_en_q   <= '0;
         disp_val_q  <= '0;
         disp_dp_q   <= '0;
         disp_en_q   <= '0;
         load_pend_q <= 1'b0;
         na_q        <= NA_OFF;
         seg_q       <= SEG_OFF;
      end else begin
         slot_q      <= slot_d;
         idx_q       <= idx_d;
         pwm_q       <= pwm_d;
         pend_val_q  <= pend_val_d;
         pend_dp_q   <= pend_dp_d;
         pend_en_q   <= pend_en_d;
         disp_val_q  <= disp_val_d;
         disp_dp_q   <= disp_dp_d;
         disp_en_q   <= disp_en_d;
         load_pend_q <= load_pend_d;
         na_q        <= na_d;
         seg_q       <= seg_d;
      end
   end

   assign NA          = na_q;
   assign SEG         = seg_q;
   assign LoadPending = load_pend_q;
   assign FrameDone   = frame_wrap && !RST;

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter NR_DIGITS, default 8, digit count (1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clocks per digit slot (>=2).
REQ-003 SHALL have parameter BRIGHT_BITS, default 4, brightness width (1..8).
REQ-004 SHALL have parameter ANODE_ACTIVE_LOW, default 1, 1 = NA active-low.
REQ-005 SHALL have parameter SEG_ACTIVE_LOW, default 1, 1 = SEG active-low.
REQ-006 SHALL have port FPGA_GlobalClock, in, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port RST, in, 1, reset, synchronous and active-high.
REQ-008 SHALL have port Value, in, 4*NR_DIGITS, hex nibble per digit; digit i = Value[4i+3:4i].
REQ-009 SHALL have port DP, in, NR_DIGITS, decimal point per digit.
REQ-010 SHALL have port DigitEn, in, NR_DIGITS, per-digit enable; 0 = blanked.
REQ-011 SHALL have port Load, in, 1, single-cycle capture strobe for Value/DP/DigitEn.
REQ-012 SHALL have port Brightness, in, BRIGHT_BITS, PWM duty code.
REQ-013 SHALL have port NA, out, NR_DIGITS, digit anode select, one-hot when lit.
REQ-014 SHALL have port SEG, out, 8, SEG[7]=dp, SEG[6:0]=g..a.
REQ-015 SHALL have port LoadPending, out, 1, captured data not yet on display.
REQ-016 SHALL have port FrameDone, out, 1, one-cycle pulse at frame boundary.

Function
REQ-017 SHALL keep slot counter 0..REFRESH_DIV-1, incrementing every clock, wrapping to 0.
REQ-018 SHALL advance digit index on slot-counter wrap: 0..NR_DIGITS-1, then back to 0.
REQ-019 SHALL pulse FrameDone for exactly the cycle in which the index goes NR_DIGITS-1 -> 0.
REQ-020 SHALL capture Value/DP/DigitEn into a pending register and set LoadPending when Load=1.
REQ-021 SHALL let a later Load overwrite a still-pending one (last wins), with LoadPending staying 1.
REQ-022 SHALL copy pending to the display register and clear LoadPending in the cycle FrameDone=1.
REQ-023 SHALL, when Load and FrameDone coincide, transfer the new Load data directly and leave LoadPending at 0.
REQ-024 SHALL use a free-running BRIGHT_BITS-wide PWM counter, incrementing every clock and wrapping.
REQ-025 SHALL drive the current digit lit iff DigitEn bit is 1 and (Brightness is all-ones, or PWM counter < Brightness).
REQ-026 SHALL produce no lit cycles when Brightness = 0.
REQ-027 SHALL, when lit, assert only the current digit's NA bit and drive the hex-decoded nibble plus that digit's DP.
REQ-028 SHALL, when not lit, drive all NA bits and all SEG bits at their inactive level.
REQ-029 SHALL decode active-high g..a as: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-030 SHALL invert NA when ANODE_ACTIVE_LOW=1 and invert SEG when SEG_ACTIVE_LOW=1.
REQ-031 SHALL register NA and SEG, giving 1 clock latency from index/PWM/display state to pins.

Reset
REQ-032 SHALL, while RST=1, clear the slot counter, digit index, PWM counter, pending and display registers, LoadPending and FrameDone.
REQ-033 SHALL hold NA and SEG at inactive level the cycle after RST is sampled high (defaults: NA all 1s, SEG=FF).
REQ-034 SHALL let RST override a simultaneous Load, discarding pending data.

Verification (NR_DIGITS=4, REFRESH_DIV=4, BRIGHT_BITS=2, active-low)
REQ-035 SHALL cover reset: RST high 2 cycles -> NA=F, SEG=FF, LoadPending=0, FrameDone=0.
REQ-036 SHALL cover scan: Load Value=0x3210, DigitEn=F, DP=0, Brightness=3 -> LoadPending=0 after first FrameDone; NA cycles E,D,B,7 every 4 clocks; SEG C0,F9,A4,B0.
REQ-037 SHALL cover load timing: two Loads mid-frame (0x1111 then 0x2222) -> display stays on old data until FrameDone; then shows 2222 (SEG A4); LoadPending 1 -> 0.
REQ-038 SHALL cover PWM: Brightness=1 -> NA active 1 of every 4 clocks; Brightness=0 -> NA stays F.
REQ-039 SHALL cover blank/DP: DigitEn=5, DP=1 -> digits 1 and 3 stay dark; digit 0 SEG=40 (0 with dp).
REQ-040 SHALL cover RST mid-frame with Load: outputs inactive next cycle; scan restarts at digit 0 with all digits blank.
